// File: rtl/decod_pkg.sv
// Shared definitions for the registered binary-to-one-hot decoder: FSM state
// encoding and default geometry.
package decod_pkg;

  localparam int DEF_IDX_W = 4;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_OUT_W = 2 ** DEF_IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational binary-to-one-hot decode; the caller registers the result.
module onehot_dec #(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]      idx,
  output logic [2**IDX_W-1:0]   onehot
);

  localparam int OUT_W = 2 ** IDX_W;

  assign onehot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;

endmodule

// File: rtl/decodificador_one_hot.sv
// Registered one-hot decoder: holds each decoded word for HOLD cycles, and can
// self-run a sweep from the top bit down to bit 0.
module decodificador_one_hot
  import decod_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int HOLD  = DEF_HOLD,
  localparam int OUT_W = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a request transfers on any rising edge where in_valid && in_ready.
  // in_ready depends only on state, so the requester may hold in_valid until then.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_none,
  input  logic             sweep_start,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam logic [7:0] CNT_RELOAD = 8'(HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] dec_idx;
  logic [OUT_W-1:0] dec_out;

  onehot_dec #(.IDX_W(IDX_W)) u_dec (
    .idx    (dec_idx),
    .onehot (dec_out)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    dec_idx     = idx_q;

    case (state_q)
      ST_IDLE: begin
        // sweep_start wins; a simultaneous request stays pending because in_ready falls.
        if (sweep_start) begin
          dec_idx     = IDX_W'(OUT_W - 1);
          idx_d       = IDX_W'(OUT_W - 1);
          out_d       = dec_out;
          out_valid_d = 1'b1;
          cnt_d       = CNT_RELOAD;
          state_d     = ST_SWEEP;
        end else if (in_valid && in_none) begin
          done_d = 1'b1;
        end else if (in_valid) begin
          dec_idx     = in_idx;
          idx_d       = in_idx;
          out_d       = dec_out;
          out_valid_d = 1'b1;
          cnt_d       = CNT_RELOAD;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          out_d       = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_SWEEP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (idx_q != '0) begin
          dec_idx = idx_q - 1'b1;
          idx_d   = idx_q - 1'b1;
          out_d   = dec_out;
          cnt_d   = CNT_RELOAD;
        end else begin
          out_d       = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_d       = '0;
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= 8'd0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_decodificador_one_hot.sv
// Directed bench for decodificador_one_hot: one instance with HOLD=4, one with HOLD=1,
// expected output words queued at stimulus time and popped as the DUT produces them.
module tb_decodificador_one_hot;

  localparam int IDX_W = 4;
  localparam int OUT_W = 16;
  localparam int H0    = 4;
  localparam int H1    = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid0, in_none0, sweep_start0, in_ready0;
  logic [IDX_W-1:0] in_idx0;
  logic [OUT_W-1:0] out0;
  logic             out_valid0, busy0, done0;
  logic [1:0]       state_dbg0;

  logic             in_valid1, in_none1, sweep_start1, in_ready1;
  logic [IDX_W-1:0] in_idx1;
  logic [OUT_W-1:0] out1;
  logic             out_valid1, busy1, done1;
  logic [1:0]       state_dbg1;

  decodificador_one_hot #(.IDX_W(IDX_W), .HOLD(H0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_idx(in_idx0), .in_none(in_none0), .sweep_start(sweep_start0),
    .out(out0), .out_valid(out_valid0), .busy(busy0), .done(done0),
    .state_dbg(state_dbg0)
  );

  decodificador_one_hot #(.IDX_W(IDX_W), .HOLD(H1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_idx(in_idx1), .in_none(in_none1), .sweep_start(sweep_start1),
    .out(out1), .out_valid(out_valid1), .busy(busy1), .done(done1),
    .state_dbg(state_dbg1)
  );

  logic [OUT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Highest-set-bit encoder standing in for the loopback priority encoder.
  function automatic logic [31:0] prio_enc(input logic [OUT_W-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    for (int b = 0; b < OUT_W; b++) if (v[b]) r = 32'(b);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("onehot0_dut0", 32'($onehot0(out0)), 32'd1);
      chk("onehot0_dut1", 32'($onehot0(out1)), 32'd1);
      chk("out_valid_dut0", 32'(out_valid0), 32'(out0 != '0));
      chk("out_valid_dut1", 32'(out_valid1), 32'(out1 != '0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int sel, input logic v, input logic [IDX_W-1:0] idx,
                         input logic none, input logic sw);
    if (sel == 0) begin
      in_valid0 = v; in_idx0 = idx; in_none0 = none; sweep_start0 = sw;
    end else begin
      in_valid1 = v; in_idx1 = idx; in_none1 = none; sweep_start1 = sw;
    end
  endtask

  task automatic sample(input int sel, output logic [OUT_W-1:0] o,
                        output logic b, output logic d, output logic r);
    o = (sel == 0) ? out0 : out1;
    b = (sel == 0) ? busy0 : busy1;
    d = (sel == 0) ? done0 : done1;
    r = (sel == 0) ? in_ready0 : in_ready1;
  endtask

  // Pops every queued word, one per cycle; the last one is the done/ready cycle.
  task automatic collect(input int sel, input string tag, input int sweep_h);
    logic [OUT_W-1:0] e, o;
    logic b, d, r;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      sample(sel, o, b, d, r);
      chk({tag, "_out"}, 32'(o), 32'(e));
      chk({tag, "_busy"}, 32'(b), 32'(e != '0));
      if (sweep_h > 0 && n < 16 * sweep_h)
        chk({tag, "_loopback"}, prio_enc(o), 32'(15 - n / sweep_h));
      if (exp_q.size() == 0) begin
        chk({tag, "_done_end"}, 32'(d), 32'd1);
        chk({tag, "_ready_end"}, 32'(r), 32'd1);
      end else begin
        chk({tag, "_done_mid"}, 32'(d), 32'd0);
        chk({tag, "_ready_mid"}, 32'(r), 32'd0);
        step();
      end
      n++;
    end
  endtask

  task automatic decode(input int sel, input logic [IDX_W-1:0] idx);
    int h;
    logic [OUT_W-1:0] o;
    logic b, d, r;
    h = (sel == 0) ? H0 : H1;
    sample(sel, o, b, d, r);
    chk("decode_ready_pre", 32'(r), 32'd1);
    set_req(sel, 1'b1, idx, 1'b0, 1'b0);
    for (int i = 0; i < h; i++) exp_q.push_back(OUT_W'(1) << idx);
    exp_q.push_back('0);
    step();
    set_req(sel, 1'b0, '0, 1'b0, 1'b0);
    collect(sel, "decode", 0);
  endtask

  initial begin
    logic [OUT_W-1:0] o;
    logic b, d, r;

    rst = 1'b1;
    set_req(0, 1'b0, '0, 1'b0, 1'b0);
    set_req(1, 1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_out", 32'(out0), 32'd0);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_state", 32'(state_dbg0), 32'd0);
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready0), 32'd1);

    decode(0, 4'hF);
    for (int i = 0; i < 16; i++) decode(0, IDX_W'(i));
    decode(1, 4'h9);

    // in_none: done next edge, nothing driven, ready never drops
    set_req(0, 1'b1, 4'h5, 1'b1, 1'b0);
    step();
    set_req(0, 1'b0, '0, 1'b0, 1'b0);
    sample(0, o, b, d, r);
    chk("none_out", 32'(o), 32'd0);
    chk("none_done", 32'(d), 32'd1);
    chk("none_ready", 32'(r), 32'd1);
    chk("none_busy", 32'(b), 32'd0);
    step();
    chk("none_done_clear", 32'(done0), 32'd0);
    chk("none_out_after", 32'(out0), 32'd0);

    // HOLD=4 sweep with a simultaneous request that must stay pending
    set_req(0, 1'b1, 4'h3, 1'b0, 1'b1);
    for (int bit_i = 15; bit_i >= 0; bit_i--)
      for (int i = 0; i < H0; i++) exp_q.push_back(OUT_W'(1) << bit_i);
    exp_q.push_back('0);
    step();
    set_req(0, 1'b1, 4'h3, 1'b0, 1'b0);
    collect(0, "sweep0", H0);
    for (int i = 0; i < H0; i++) exp_q.push_back(OUT_W'(1) << 3);
    exp_q.push_back('0);
    step();
    set_req(0, 1'b0, '0, 1'b0, 1'b0);
    collect(0, "pending", 0);

    // HOLD=1 sweep; request held during sweep must not be taken
    set_req(1, 1'b0, '0, 1'b0, 1'b1);
    for (int bit_i = 15; bit_i >= 0; bit_i--) exp_q.push_back(OUT_W'(1) << bit_i);
    exp_q.push_back('0);
    step();
    set_req(1, 1'b1, 4'h9, 1'b0, 1'b0);
    collect(1, "sweep1", H1);
    set_req(1, 1'b0, '0, 1'b0, 1'b0);
    step();
    chk("sweep1_no_accept_out", 32'(out1), 32'd0);
    chk("sweep1_no_accept_busy", 32'(busy1), 32'd0);
    chk("sweep1_no_accept_done", 32'(done1), 32'd0);

    // Reset in the 2nd cycle of a HOLD
    set_req(0, 1'b1, 4'h7, 1'b0, 1'b0);
    step();
    set_req(0, 1'b0, '0, 1'b0, 1'b0);
    chk("mid_rst_pre_out", 32'(out0), 32'h0080);
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_out", 32'(out0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid0), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_done", 32'(done0), 32'd0);
    chk("post_rst_ready", 32'(in_ready0), 32'd1);
    decode(0, 4'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
